// File: rtl/register_file_mp_if.sv
// Request/response bundle for the miniMIPS register file: two read ports, one write port,
// registered read data with a valid strobe, and the init-sweep busy flag.
interface register_file_mp_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
);
   logic                  READ;
   logic                  WRITE;
   logic [ADDR_WIDTH-1:0] ADDR_R1;
   logic [ADDR_WIDTH-1:0] ADDR_R2;
   logic [ADDR_WIDTH-1:0] ADDR_W;
   logic [DATA_WIDTH-1:0] DATA_W;
   logic [DATA_WIDTH-1:0] DATA_R1;
   logic [DATA_WIDTH-1:0] DATA_R2;
   logic                  RD_VALID;
   logic                  BUSY;

   modport master (
      output READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
      input  DATA_R1, DATA_R2, RD_VALID, BUSY
   );

   modport slave (
      input  READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
      output DATA_R1, DATA_R2, RD_VALID, BUSY
   );
endinterface

// File: rtl/register_file_mp.sv
// Parametrised 2R/1W register file with init sweep, registered reads and write-through forwarding.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module register_file_mp #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DEPTH      = 32
) (
   input logic                CLK,
   input logic                RST,
   register_file_mp_if.slave  bus
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {INIT, READY} state_t;

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  mem_we;
   logic [IDX_W-1:0]      mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   logic [DATA_WIDTH-1:0] data_r1_q, data_r2_q, data_r1_nxt, data_r2_nxt;
   logic                  rd_valid_q, rd_valid_nxt;
   logic                  busy_q, busy_nxt;

   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] mem_r1, mem_r2;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

   // Final read value for one port: hardwired zero, forwarded write, array, or out-of-range zero.
   function automatic logic [DATA_WIDTH-1:0] rd_sel(
      input logic [ADDR_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] word,
      input logic                  fwd_en,
      input logic [ADDR_WIDTH-1:0] aw,
      input logic [DATA_WIDTH-1:0] dw
   );
`ifdef REGFILE_ZERO_REG_EN
      if (a == '0) return '0;
`endif
      if (fwd_en && (a == aw)) return dw;
      if (in_range(a)) return word;
      return '0;
   endfunction

`ifdef REGFILE_ZERO_REG_EN
   assign wr_ok = bus.WRITE && in_range(bus.ADDR_W) && (bus.ADDR_W != '0);
`else
   assign wr_ok = bus.WRITE && in_range(bus.ADDR_W);
`endif

   assign mem_r1 = mem[bus.ADDR_R1[IDX_W-1:0]];
   assign mem_r2 = mem[bus.ADDR_R2[IDX_W-1:0]];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= INIT;
         cnt        <= '0;
         busy_q     <= 1'b1;
         rd_valid_q <= 1'b0;
         data_r1_q  <= '0;
         data_r2_q  <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         busy_q     <= busy_nxt;
         rd_valid_q <= rd_valid_nxt;
         data_r1_q  <= data_r1_nxt;
         data_r2_q  <= data_r2_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      busy_nxt     = busy_q;
      rd_valid_nxt = 1'b0;
      data_r1_nxt  = data_r1_q;
      data_r2_nxt  = data_r2_q;
      mem_we       = 1'b0;
      mem_waddr    = cnt;
      mem_wdata    = DATA_WIDTH'(cnt);
      case (state)
         INIT: begin
            // Sweep writes each register with its own index; requests are ignored.
            mem_we   = 1'b1;
            cnt_nxt  = cnt + IDX_W'(1);
            busy_nxt = 1'b1;
            if (cnt == IDX_W'(DEPTH - 1)) begin
               state_nxt = READY;
               cnt_nxt   = '0;
               busy_nxt  = 1'b0;
            end
         end
         READY: begin
            busy_nxt = 1'b0;
            if (wr_ok) begin
               mem_we    = 1'b1;
               mem_waddr = bus.ADDR_W[IDX_W-1:0];
               mem_wdata = bus.DATA_W;
            end
            if (bus.READ) begin
               rd_valid_nxt = 1'b1;
               data_r1_nxt  = rd_sel(bus.ADDR_R1, mem_r1, wr_ok, bus.ADDR_W, bus.DATA_W);
               data_r2_nxt  = rd_sel(bus.ADDR_R2, mem_r2, wr_ok, bus.ADDR_W, bus.DATA_W);
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST && mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign bus.DATA_R1  = data_r1_q;
   assign bus.DATA_R2  = data_r2_q;
   assign bus.RD_VALID = rd_valid_q;
   assign bus.BUSY     = busy_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: a 32-deep and a 16-deep instance checked
// against an array-based model of the register file's architectural behaviour.
module tb_register_file_mp;
`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   register_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b32 ();
   register_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b16 ();

   register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32)) dut32 (
      .CLK(CLK), .RST(RST), .bus(b32));
   register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16)) dut16 (
      .CLK(CLK), .RST(RST), .bus(b16));

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] model32 [32];
   logic [31:0] model16 [16];
   logic [31:0] exp1_32, exp2_32, exp1_16, exp2_16;

   // Architectural model: after the sweep reg[i] == i; outputs clear on reset.
   task automatic model_init();
      for (int i = 0; i < 32; i++) model32[i] = 32'(i);
      for (int i = 0; i < 16; i++) model16[i] = 32'(i);
      exp1_32 = '0; exp2_32 = '0; exp1_16 = '0; exp2_16 = '0;
   endtask

   // A write lands first, so a same-cycle read of that address sees the new value.
   task automatic model32_step(input bit rd, input bit wr, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] aw, input logic [31:0] dw);
      if (wr && !(ZERO_REG && aw == 0)) model32[aw] = dw;
      if (rd) begin
         exp1_32 = model32[a1];
         exp2_32 = model32[a2];
      end
   endtask

   task automatic model16_step(input bit rd, input bit wr, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] aw, input logic [31:0] dw);
      if (wr && aw < 16 && !(ZERO_REG && aw == 0)) model16[aw[3:0]] = dw;
      if (rd) begin
         exp1_16 = (a1 < 16) ? model16[a1[3:0]] : 32'h0;
         exp2_16 = (a2 < 16) ? model16[a2[3:0]] : 32'h0;
      end
   endtask

   task automatic drive32(input bit rd, input bit wr, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] aw, input logic [31:0] dw);
      b32.READ = rd; b32.WRITE = wr; b32.ADDR_R1 = a1; b32.ADDR_R2 = a2;
      b32.ADDR_W = aw; b32.DATA_W = dw;
      @(posedge CLK); #1;
      b32.READ = 1'b0; b32.WRITE = 1'b0;
   endtask

   task automatic drive16(input bit rd, input bit wr, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] aw, input logic [31:0] dw);
      b16.READ = rd; b16.WRITE = wr; b16.ADDR_R1 = a1; b16.ADDR_R2 = a2;
      b16.ADDR_W = aw; b16.DATA_W = dw;
      @(posedge CLK); #1;
      b16.READ = 1'b0; b16.WRITE = 1'b0;
   endtask

   // Releases reset and counts cycles until BUSY falls on both instances.
   task automatic release_and_sweep(input string tag);
      int n = 0;
      int n16 = -1;
      RST = 1'b0;
      while (b32.BUSY && n < 100) begin
         @(posedge CLK); #1;
         n++;
         if (n16 < 0 && !b16.BUSY) n16 = n;
      end
      n_total++;
      if (n !== 32) $display("FAIL %s busy32_cycles got=%0d exp=32", tag, n);
      else n_pass++;
      n_total++;
      if (n16 !== 16) $display("FAIL %s busy16_cycles got=%0d exp=16", tag, n16);
      else n_pass++;
      model_init();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      b32.READ = 0; b32.WRITE = 0; b32.ADDR_R1 = 0; b32.ADDR_R2 = 0; b32.ADDR_W = 0; b32.DATA_W = 0;
      b16.READ = 0; b16.WRITE = 0; b16.ADDR_R1 = 0; b16.ADDR_R2 = 0; b16.ADDR_W = 0; b16.DATA_W = 0;
      repeat (2) @(posedge CLK);
      #1;
      n_total++;
      if ({b32.BUSY, b32.RD_VALID} !== 2'b10) $display("FAIL reset_flags got=%b exp=10", {b32.BUSY, b32.RD_VALID});
      else n_pass++;
      n_total++;
      if ({b32.DATA_R1, b32.DATA_R2} !== 64'h0) $display("FAIL reset_data got=%h exp=0", {b32.DATA_R1, b32.DATA_R2});
      else n_pass++;
      release_and_sweep("reset");
      drive32(1, 0, 5'd7, 5'd31, 0, 0);
      n_total++;
      if ({b32.RD_VALID, b32.DATA_R1, b32.DATA_R2} !== {1'b1, 32'd7, 32'd31})
         $display("FAIL sweep_read valid=%b r1=%h r2=%h exp 1/7/31", b32.RD_VALID, b32.DATA_R1, b32.DATA_R2);
      else n_pass++;
      drive32(0, 0, 5'd1, 5'd2, 0, 0);
      n_total++;
      if ({b32.RD_VALID, b32.DATA_R1, b32.DATA_R2} !== {1'b0, 32'd7, 32'd31})
         $display("FAIL idle_hold valid=%b r1=%h r2=%h exp 0/7/31", b32.RD_VALID, b32.DATA_R1, b32.DATA_R2);
      else n_pass++;
   endtask

   task automatic test_write_read();
      drive32(0, 1, 0, 0, 5'd5, 32'hDEADBEEF);
      model32_step(0, 1, 0, 0, 5'd5, 32'hDEADBEEF);
      drive32(1, 0, 5'd5, 5'd6, 0, 0);
      n_total++;
      if ({b32.RD_VALID, b32.DATA_R1, b32.DATA_R2} !== {1'b1, 32'hDEADBEEF, 32'd6})
         $display("FAIL write_read valid=%b r1=%h r2=%h exp 1/deadbeef/6", b32.RD_VALID, b32.DATA_R1, b32.DATA_R2);
      else n_pass++;
   endtask

   task automatic test_forward();
      drive32(1, 1, 5'd9, 5'd9, 5'd9, 32'h12345678);
      model32_step(1, 1, 5'd9, 5'd9, 5'd9, 32'h12345678);
      n_total++;
      if ({b32.DATA_R1, b32.DATA_R2} !== {32'h12345678, 32'h12345678})
         $display("FAIL forward r1=%h r2=%h exp 12345678", b32.DATA_R1, b32.DATA_R2);
      else n_pass++;
      drive32(1, 0, 5'd9, 5'd8, 0, 0);
      n_total++;
      if ({b32.DATA_R1, b32.DATA_R2} !== {32'h12345678, 32'd8})
         $display("FAIL forward_persist r1=%h r2=%h exp 12345678/8", b32.DATA_R1, b32.DATA_R2);
      else n_pass++;
   endtask

   task automatic test_zero_reg();
      logic [31:0] exp0;
      exp0 = ZERO_REG ? 32'h0 : 32'hFFFFFFFF;
      drive32(0, 1, 0, 0, 5'd0, 32'hFFFFFFFF);
      model32_step(0, 1, 0, 0, 5'd0, 32'hFFFFFFFF);
      drive32(1, 0, 5'd0, 5'd1, 0, 0);
      n_total++;
      if ({b32.DATA_R1, b32.DATA_R2} !== {exp0, 32'd1})
         $display("FAIL zero_reg r1=%h r2=%h exp %h/1", b32.DATA_R1, b32.DATA_R2, exp0);
      else n_pass++;
      drive32(1, 1, 5'd0, 5'd0, 5'd0, 32'h0BADF00D);
      model32_step(1, 1, 5'd0, 5'd0, 5'd0, 32'h0BADF00D);
      n_total++;
      if (b32.DATA_R1 !== exp1_32) $display("FAIL zero_reg_fwd got=%h exp=%h", b32.DATA_R1, exp1_32);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 300; i++) begin
         bit rd, wr;
         logic [4:0] a1, a2, aw;
         logic [31:0] dw;
         rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
         a1 = 5'($urandom); a2 = 5'($urandom); aw = 5'($urandom); dw = $urandom;
         if ($urandom_range(0, 3) == 0) a1 = aw;
         if ($urandom_range(0, 5) == 0) aw = 5'd0;
         drive32(rd, wr, a1, a2, aw, dw);
         model32_step(rd, wr, a1, a2, aw, dw);
         n_total++;
         if ({b32.RD_VALID, b32.DATA_R1, b32.DATA_R2} !== {rd, exp1_32, exp2_32}) begin
            if (errs < 10) $display("FAIL random[%0d] valid=%b r1=%h r2=%h exp %b/%h/%h",
               i, b32.RD_VALID, b32.DATA_R1, b32.DATA_R2, rd, exp1_32, exp2_32);
            errs++;
         end else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 32; i++) begin
         logic [4:0] a1, a2;
         a1 = 5'(i); a2 = 5'(31 - i);
         drive32(1, 0, a1, a2, 0, 0);
         model32_step(1, 0, a1, a2, 0, 0);
         n_total++;
         if ({b32.RD_VALID, b32.DATA_R1, b32.DATA_R2} !== {1'b1, exp1_32, exp2_32})
            $display("FAIL b2b[%0d] valid=%b r1=%h r2=%h exp 1/%h/%h",
               i, b32.RD_VALID, b32.DATA_R1, b32.DATA_R2, exp1_32, exp2_32);
         else n_pass++;
      end
   endtask

   task automatic test_out_of_range();
      drive16(0, 1, 0, 0, 5'd20, 32'hAAAA);
      model16_step(0, 1, 0, 0, 5'd20, 32'hAAAA);
      drive16(1, 0, 5'd20, 5'd4, 0, 0);
      n_total++;
      if ({b16.RD_VALID, b16.DATA_R1, b16.DATA_R2} !== {1'b1, 32'h0, 32'd4})
         $display("FAIL oor_read valid=%b r1=%h r2=%h exp 1/0/4", b16.RD_VALID, b16.DATA_R1, b16.DATA_R2);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         logic [4:0] a1, a2;
         a1 = 5'(i); a2 = 5'(i + 8);
         drive16(1, 0, a1, a2, 0, 0);
         model16_step(1, 0, a1, a2, 0, 0);
         n_total++;
         if ({b16.DATA_R1, b16.DATA_R2} !== {exp1_16, exp2_16})
            $display("FAIL oor_intact[%0d] r1=%h r2=%h exp %h/%h", i, b16.DATA_R1, b16.DATA_R2, exp1_16, exp2_16);
         else n_pass++;
      end
      for (int i = 0; i < 100; i++) begin
         bit rd, wr;
         logic [4:0] a1, a2, aw;
         logic [31:0] dw;
         rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
         a1 = 5'($urandom); a2 = 5'($urandom); aw = 5'($urandom); dw = $urandom;
         if ($urandom_range(0, 3) == 0) a2 = aw;
         drive16(rd, wr, a1, a2, aw, dw);
         model16_step(rd, wr, a1, a2, aw, dw);
         n_total++;
         if ({b16.RD_VALID, b16.DATA_R1, b16.DATA_R2} !== {rd, exp1_16, exp2_16})
            $display("FAIL rand16[%0d] valid=%b r1=%h r2=%h exp %b/%h/%h",
               i, b16.RD_VALID, b16.DATA_R1, b16.DATA_R2, rd, exp1_16, exp2_16);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_sweep();
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive32(1, 1, 5'd3, 5'd5, 5'd3, 32'h5555);
         n_total++;
         if ({b32.BUSY, b32.RD_VALID} !== 2'b10)
            $display("FAIL busy_ignore[%0d] busy/valid got=%b exp=10", i, {b32.BUSY, b32.RD_VALID});
         else n_pass++;
      end
      RST = 1'b1;
      @(posedge CLK); #1;
      n_total++;
      if ({b32.BUSY, b32.DATA_R1} !== {1'b1, 32'h0}) $display("FAIL mid_reset busy=%b r1=%h exp 1/0", b32.BUSY, b32.DATA_R1);
      else n_pass++;
      release_and_sweep("mid_sweep");
      drive32(1, 0, 5'd3, 5'd5, 0, 0);
      model32_step(1, 0, 5'd3, 5'd5, 0, 0);
      n_total++;
      if ({b32.RD_VALID, b32.DATA_R1, b32.DATA_R2} !== {1'b1, exp1_32, exp2_32})
         $display("FAIL write_lost valid=%b r1=%h r2=%h exp 1/%h/%h", b32.RD_VALID, b32.DATA_R1, b32.DATA_R2, exp1_32, exp2_32);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_forward();
      test_zero_reg();
      test_random();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_sweep();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
